msg_sequencer: RTL and testbench

//  Sequences one AES test message per start command: issues N word-requests to the word generator

---
 rtl/aes_top_pack.sv | 21 ++
 rtl/seq_watchdog.sv | 31 +++
 rtl/msg_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_msg_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_top_pack.sv
// Shared types and sizes for the AES test-message datapath.
package aes_top_pack;

  localparam int WORD_COUNTER_SIZE = 8;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_DRAIN,
    SEQ_DONE,
    SEQ_ERROR
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_TIMEOUT,
    ERR_MISMATCH,
    ERR_ABORT
  } seq_err_t;

endpackage

// File: rtl/seq_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles without a clear. expired is high
// during the TIMEOUT_CYCLES-th consecutive idle cycle, so the owner can react
// on the following edge.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  assign expired = enable && !clear && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter, held at zero while disabled, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/msg_sequencer.sv
// Sequences one AES test message per start: issues N word requests to the
// generator, waits for the remover count to advance by N, then checks that
// the adder count advanced by N as well. Reports done/err with a watchdog.
//
// state      | meaning
// SEQ_IDLE   | waiting for cfg_start
// SEQ_ISSUE  | gen_valid high, counting handshakes up to N
// SEQ_DRAIN  | all requests issued, waiting for remover to advance by N
// SEQ_DONE   | done pulse, busy drops
// SEQ_ERROR  | err pulse, busy drops, err_code holds the cause
module msg_sequencer
  import aes_top_pack::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int WORD_W         = WORD_COUNTER_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] cfg_words,
  input  logic              cfg_abort,
  output logic              gen_valid,
  output logic              gen_last,
  input  logic              gen_ready,
  input  logic [WORD_W-1:0] adder_cnt,
  input  logic [WORD_W-1:0] remover_cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [WORD_W-1:0] issued_cnt
);

  seq_state_t        state_q, state_d;
  seq_err_t          err_code_q, err_code_d;
  logic [WORD_W-1:0] n_q, n_d;
  logic [WORD_W-1:0] add_snap_q, add_snap_d;
  logic [WORD_W-1:0] rem_snap_q, rem_snap_d;
  logic [WORD_W-1:0] add_prev_q, rem_prev_q;
  logic [WORD_W-1:0] issued_q, issued_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              hs;
  logic              progress;
  logic              start_accept;
  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expired;
  logic [WORD_W-1:0] rem_delta;
  logic [WORD_W-1:0] add_delta;
  logic              complete;
  logic              match;

  assign gen_valid  = (state_q == SEQ_ISSUE);
  assign gen_last   = gen_valid && (issued_q == n_q - 1'b1);
  assign hs         = gen_valid && gen_ready;

  // Counter deltas are taken modulo 2^WORD_W, so wrapping counts still match.
  assign rem_delta  = remover_cnt - rem_snap_q;
  assign add_delta  = adder_cnt - add_snap_q;
  assign complete   = (rem_delta == n_q);
  assign match      = (add_delta == n_q);

  assign start_accept = (state_q == SEQ_IDLE) && cfg_start && (cfg_words != '0);
  assign progress     = hs || (adder_cnt != add_prev_q) || (remover_cnt != rem_prev_q);
  assign wd_clear     = progress || start_accept;
  assign wd_enable    = (state_q == SEQ_ISSUE) || (state_q == SEQ_DRAIN);

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign issued_cnt = issued_q;

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Next-state and register-update decisions; abort > timeout > completion > handshake.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    n_d        = n_q;
    add_snap_d = add_snap_q;
    rem_snap_d = rem_snap_q;
    issued_d   = issued_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (cfg_start) begin
          err_code_d = ERR_NONE;
          if (cfg_words != '0) begin
            n_d        = cfg_words;
            add_snap_d = adder_cnt;
            rem_snap_d = remover_cnt;
            issued_d   = '0;
            busy_d     = 1'b1;
            state_d    = SEQ_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEQ_ISSUE: begin
        if (cfg_abort) begin
          err_code_d = ERR_ABORT;
          err_d      = 1'b1;
          state_d    = SEQ_ERROR;
        end else if (wd_expired) begin
          err_code_d = ERR_TIMEOUT;
          err_d      = 1'b1;
          state_d    = SEQ_ERROR;
        end else if (hs) begin
          issued_d = issued_q + 1'b1;
          if (gen_last) begin
            state_d = SEQ_DRAIN;
          end
        end
      end
      SEQ_DRAIN: begin
        if (cfg_abort) begin
          err_code_d = ERR_ABORT;
          err_d      = 1'b1;
          state_d    = SEQ_ERROR;
        end else if (wd_expired) begin
          err_code_d = ERR_TIMEOUT;
          err_d      = 1'b1;
          state_d    = SEQ_ERROR;
        end else if (complete) begin
          if (match) begin
            done_d  = 1'b1;
            state_d = SEQ_DONE;
          end else begin
            err_code_d = ERR_MISMATCH;
            err_d      = 1'b1;
            state_d    = SEQ_ERROR;
          end
        end
      end
      SEQ_DONE, SEQ_ERROR: begin
        busy_d  = 1'b0;
        state_d = SEQ_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // State, snapshots, counters and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_IDLE;
      err_code_q <= ERR_NONE;
      n_q        <= '0;
      add_snap_q <= '0;
      rem_snap_q <= '0;
      add_prev_q <= '0;
      rem_prev_q <= '0;
      issued_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      n_q        <= n_d;
      add_snap_q <= add_snap_d;
      rem_snap_q <= rem_snap_d;
      add_prev_q <= adder_cnt;
      rem_prev_q <= remover_cnt;
      issued_q   <= issued_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_msg_sequencer.sv
// Bench for msg_sequencer: table of message vectors plus hand-written
// abort / zero-length / reset sequences. Expected done/err outcomes are
// queued when a message is started and compared when the pulse appears.
module tb_msg_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start;
  logic [7:0] cfg_words;
  logic       cfg_abort;
  logic       gen_valid;
  logic       gen_last;
  logic       gen_ready;
  logic [7:0] adder_cnt;
  logic [7:0] remover_cnt;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] issued_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    int         issued;
  } exp_t;

  typedef struct {
    int         n;
    logic [7:0] add_base;
    logic [7:0] rem_base;
    int         rdy_mode;
    int         add_adv;
    int         rem_adv;
    bit         is_err;
    logic [1:0] code;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  msg_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .WORD_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_words  (cfg_words),
    .cfg_abort  (cfg_abort),
    .gen_valid  (gen_valid),
    .gen_last   (gen_last),
    .gen_ready  (gen_ready),
    .adder_cnt  (adder_cnt),
    .remover_cnt(remover_cnt),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (done || err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b, required no pulse", done, err);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {30'd0, err, done}, e.is_err ? 2 : 1);
        check("err_code", err_code, e.code);
        if (e.issued >= 0) check("issued_at_end", issued_cnt, e.issued);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int  hs, last_cnt, add_left, rem_left, last_prog, rem_fin, pulse;
    bit  issue_done, valid_ok, track_ok, last_ok, drain_ok;
    adder_cnt   = v.add_base;
    remover_cnt = v.rem_base;
    step();
    step();
    sb.push_back('{is_err: v.is_err, code: v.code, issued: v.n});
    cfg_words = 8'(v.n);
    cfg_start = 1'b1;
    gen_ready = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_valid_in_start_cycle", idx), gen_valid, 0);
    step();
    cfg_start  = 1'b0;
    hs = 0; last_cnt = 0; add_left = v.add_adv; rem_left = v.rem_adv;
    last_prog = -1; rem_fin = -1; pulse = -1;
    issue_done = 0; valid_ok = 1; track_ok = 1; last_ok = 1; drain_ok = 1;
    for (int c = 0; c < 1500; c++) begin
      gen_ready = (v.rdy_mode == 0) ? 1'b1 : ((c % 2) == 0);
      if (issue_done) begin
        if (add_left > 0) begin
          adder_cnt = adder_cnt + 8'd1;
          add_left--;
          last_prog = cyc;
        end
        if (rem_left > 0) begin
          remover_cnt = remover_cnt + 8'd1;
          rem_left--;
          last_prog = cyc;
          if (rem_left == 0) rem_fin = cyc;
        end
      end
      @(negedge clk);
      if (done || err) begin
        pulse = cyc;
        break;
      end
      if (!issue_done) begin
        if (!gen_valid) valid_ok = 0;
        if (issued_cnt != 8'(hs)) track_ok = 0;
        if (gen_valid && gen_ready) begin
          if (gen_last != (hs == v.n - 1)) last_ok = 0;
          if (gen_last) last_cnt++;
          hs++;
          last_prog = cyc;
          if (hs == v.n) issue_done = 1;
        end
      end else if (gen_valid) begin
        drain_ok = 0;
      end
      step();
    end
    if (pulse < 0) begin
      checks++;
      errors++;
      $display("FAIL v%0d_no_pulse: got none within budget, required done/err", idx);
      sb.delete();
    end else begin
      check($sformatf("v%0d_handshakes", idx), hs, v.n);
      check($sformatf("v%0d_last_count", idx), last_cnt, 1);
      check($sformatf("v%0d_valid_held", idx), valid_ok, 1);
      check($sformatf("v%0d_issued_track", idx), track_ok, 1);
      check($sformatf("v%0d_last_position", idx), last_ok, 1);
      check($sformatf("v%0d_drain_valid_low", idx), drain_ok, 1);
      if (v.code == 2'd1) check($sformatf("v%0d_timeout_latency", idx), pulse - last_prog, TO + 1);
      else check($sformatf("v%0d_completion_latency", idx), pulse - rem_fin, 1);
    end
    step();
    step();
  endtask

  initial begin
    cfg_start = 1'b0; cfg_words = 8'd0; cfg_abort = 1'b0;
    gen_ready = 1'b0; adder_cnt = 8'd0; remover_cnt = 8'd0;

    vecs[0] = '{n: 4,   add_base: 8'd10,  rem_base: 8'd20,  rdy_mode: 0, add_adv: 4,   rem_adv: 5 - 1, is_err: 0, code: 2'd0};
    vecs[1] = '{n: 3,   add_base: 8'd50,  rem_base: 8'd60,  rdy_mode: 1, add_adv: 3,   rem_adv: 3,     is_err: 0, code: 2'd0};
    vecs[2] = '{n: 5,   add_base: 8'd100, rem_base: 8'd253, rdy_mode: 0, add_adv: 4,   rem_adv: 5,     is_err: 1, code: 2'd2};
    vecs[3] = '{n: 2,   add_base: 8'd7,   rem_base: 8'd9,   rdy_mode: 0, add_adv: 0,   rem_adv: 0,     is_err: 1, code: 2'd1};
    vecs[4] = '{n: 255, add_base: 8'd250, rem_base: 8'd10,  rdy_mode: 0, add_adv: 255, rem_adv: 255,   is_err: 0, code: 2'd0};
    vecs[5] = '{n: 1,   add_base: 8'd255, rem_base: 8'd255, rdy_mode: 1, add_adv: 1,   rem_adv: 1,     is_err: 0, code: 2'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {19'd0, gen_valid, gen_last, busy, done, err, err_code, issued_cnt}, 0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Abort after one handshake, with an ignored start in between.
    sb.push_back('{is_err: 1, code: 2'd3, issued: 1});
    cfg_words = 8'd4; cfg_start = 1'b1; gen_ready = 1'b1;
    @(negedge clk);
    step();
    cfg_start = 1'b0;
    @(negedge clk);
    check("abort_first_valid", gen_valid, 1);
    step();
    gen_ready = 1'b0; cfg_start = 1'b1; cfg_words = 8'd7;
    @(negedge clk);
    check("abort_valid_held", gen_valid, 1);
    step();
    cfg_start = 1'b0; cfg_abort = 1'b1; gen_ready = 1'b1;
    @(negedge clk);
    check("busy_start_ignored_issued", issued_cnt, 1);
    check("busy_start_ignored_busy", busy, 1);
    step();
    cfg_abort = 1'b0; gen_ready = 1'b0;
    @(negedge clk);
    check("abort_valid_low", gen_valid, 0);
    check("abort_err_pulse", err, 1);
    step();
    step();
    @(negedge clk);
    check("abort_code_held", err_code, 3);
    check("abort_busy_low", busy, 0);
    step();

    // Zero-length message: done next cycle, no request, code cleared.
    sb.push_back('{is_err: 0, code: 2'd0, issued: -1});
    cfg_words = 8'd0; cfg_start = 1'b1;
    @(negedge clk);
    check("zero_valid_start", gen_valid, 0);
    step();
    cfg_start = 1'b0;
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_valid", gen_valid, 0);
    check("zero_busy", busy, 0);
    check("zero_code_cleared", err_code, 0);
    step();
    @(negedge clk);
    check("zero_done_single", done, 0);
    step();

    // Reset asserted in DRAIN: everything returns to zero, no pulse.
    cfg_words = 8'd2; cfg_start = 1'b1; gen_ready = 1'b1;
    @(negedge clk);
    step();
    cfg_start = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    gen_ready = 1'b0;
    @(negedge clk);
    check("drain_before_reset", {30'd0, busy, gen_valid}, 2);
    step();
    rst_n = 1'b0;
    #1;
    check("reset_mid_drain", {19'd0, gen_valid, gen_last, busy, done, err, err_code, issued_cnt}, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (TO + 4) step();

    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
